// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg: FFT sequencer constants, FSM state encoding, bitrev/rotl helpers.
// Rev 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int N_LOG2_DEFAULT = 5;
  localparam int MAX_W          = 10;
  localparam int STAGE_W        = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Reverse the low w bits of x; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] y;
    logic [MAX_W-1:0] t;
    y = '0;
    t = x;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < w) begin
        y = {y[MAX_W-2:0], t[0]};
        t = t >> 1;
      end
    end
    return y;
  endfunction

  // Rotate the low w bits of x left by s positions.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int s, input int w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] y;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    y    = x & mask;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < s) begin
        y = ((y << 1) | (y >> (w - 1))) & mask;
      end
    end
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_ctrl_addr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_addr_gen: maps (stage, butterfly index) to read pair and twiddle address.
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEFAULT
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [N_LOG2-2:0]  bfly,
  output logic [N_LOG2-1:0]  adr_a,
  output logic [N_LOG2-1:0]  adr_b,
  output logic [N_LOG2-2:0]  tw
);

  logic [N_LOG2-2:0] tw_low;

  // Twiddle keeps only the top 'stage' bits of the butterfly index.
  always_comb begin
    adr_a  = N_LOG2'(rotl(MAX_W'({bfly, 1'b0}), int'(stage), N_LOG2));
    adr_b  = N_LOG2'(rotl(MAX_W'({bfly, 1'b1}), int'(stage), N_LOG2));
    tw_low = {(N_LOG2-1){1'b1}} >> stage;
    tw     = bfly & ~tw_low;
  end

endmodule
`default_nettype wire

// File: rtl/fft_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_ctrl: radix-2 DIT FFT sequencer (bit-reversed load, stage/butterfly
// stepping, RAM ping-pong). Optional block scaling: FFT_BLOCK_SCALE_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              load_valid,
  output logic              busy,
  output logic              done,
  output logic              result_bank,
  output logic              ram0_sel_load,
  output logic              rd_bank,
  output logic [N_LOG2-1:0] rd_adr_a,
  output logic [N_LOG2-1:0] rd_adr_b,
  output logic [N_LOG2-2:0] tw_adr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_adr_a,
  output logic [N_LOG2-1:0] wr_adr_b,
  output logic [N_LOG2-1:0] ld_adr,
  output logic              ld_we,
  output logic              bfu_scale
);

  localparam logic [N_LOG2-1:0]  LAST_SAMPLE = '1;
  localparam logic [N_LOG2-2:0]  LAST_BFLY   = '1;
  localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(N_LOG2 - 1);
  localparam logic               FINAL_BANK  = 1'(N_LOG2 % 2);

  state_t              state, state_n;
  logic [N_LOG2-1:0]   ld_cnt, ld_cnt_n;
  logic [STAGE_W-1:0]  stage, stage_n;
  logic [N_LOG2-2:0]   bfly, bfly_n;
  logic                in_compute;
  logic [N_LOG2-1:0]   gen_a, gen_b;
  logic [N_LOG2-2:0]   gen_tw;

  fft_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .stage  (stage),
    .bfly   (bfly),
    .adr_a  (gen_a),
    .adr_b  (gen_b),
    .tw     (gen_tw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ld_cnt <= '0;
      stage  <= '0;
      bfly   <= '0;
    end else begin
      state  <= state_n;
      ld_cnt <= ld_cnt_n;
      stage  <= stage_n;
      bfly   <= bfly_n;
    end
  end

  always_comb begin
    state_n       = state;
    ld_cnt_n      = ld_cnt;
    stage_n       = stage;
    bfly_n        = bfly;
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    ram0_sel_load = (state == S_LOAD);
    ld_we         = (state == S_LOAD) && load_valid;
    in_compute    = (state == S_COMPUTE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_LOAD;
          ld_cnt_n = '0;
          stage_n  = '0;
          bfly_n   = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          ld_cnt_n = ld_cnt + 1'b1;
          if (ld_cnt == LAST_SAMPLE) begin
            state_n = S_COMPUTE;
            stage_n = '0;
            bfly_n  = '0;
          end
        end
      end
      S_COMPUTE: begin
        bfly_n = bfly + 1'b1;
        if (bfly == LAST_BFLY) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Bubble lets the last write of this stage land before the next stage reads.
        stage_n = stage + 1'b1;
        if (stage == LAST_STAGE) begin
          state_n = S_DONE;
        end else begin
          state_n = S_COMPUTE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        stage_n = '0;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign rd_bank  = stage[0];
  assign rd_adr_a = in_compute ? gen_a  : '0;
  assign rd_adr_b = in_compute ? gen_b  : '0;
  assign tw_adr   = in_compute ? gen_tw : '0;
  assign ld_adr   = N_LOG2'(bitrev(MAX_W'(ld_cnt), N_LOG2));

  // Write side trails the read side by the 1-cycle RAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en       <= 1'b0;
      wr_adr_a    <= '0;
      wr_adr_b    <= '0;
      result_bank <= 1'b0;
    end else begin
      wr_en    <= in_compute;
      wr_adr_a <= rd_adr_a;
      wr_adr_b <= rd_adr_b;
      if ((state == S_DRAIN) && (stage == LAST_STAGE)) begin
        result_bank <= FINAL_BANK;
      end
    end
  end

`ifdef FFT_BLOCK_SCALE_EN
  assign bfu_scale = wr_en;
`else
  assign bfu_scale = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_ctrl: directed self-checking bench for fft_ctrl (N_LOG2 = 3 and 5).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fft_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       start3, lv3, busy3, done3, rbank3, sel3, bank3, wen3, ldwe3, scale3;
  logic [2:0] rda3, rdb3, wra3, wrb3, lda3;
  logic [1:0] tw3;

  logic       start5, lv5, busy5, done5, rbank5, sel5, bank5, wen5, ldwe5, scale5;
  logic [4:0] rda5, rdb5, wra5, wrb5, lda5;
  logic [3:0] tw5;

`ifdef FFT_BLOCK_SCALE_EN
  localparam int SCALE_EXP5 = 80;
`else
  localparam int SCALE_EXP5 = 0;
`endif

  fft_ctrl #(.N_LOG2(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .load_valid(lv3),
    .busy(busy3), .done(done3), .result_bank(rbank3), .ram0_sel_load(sel3),
    .rd_bank(bank3), .rd_adr_a(rda3), .rd_adr_b(rdb3), .tw_adr(tw3),
    .wr_en(wen3), .wr_adr_a(wra3), .wr_adr_b(wrb3), .ld_adr(lda3),
    .ld_we(ldwe3), .bfu_scale(scale3)
  );

  fft_ctrl #(.N_LOG2(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .load_valid(lv5),
    .busy(busy5), .done(done5), .result_bank(rbank5), .ram0_sel_load(sel5),
    .rd_bank(bank5), .rd_adr_a(rda5), .rd_adr_b(rdb5), .tw_adr(tw5),
    .wr_en(wen5), .wr_adr_a(wra5), .wr_adr_b(wrb5), .ld_adr(lda5),
    .ld_we(ldwe5), .bfu_scale(scale5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_rotl(input int x, input int s, input int l);
    return ((x << s) | (x >> (l - s))) & ((1 << l) - 1);
  endfunction

  function automatic int m_tw(input int i, input int s, input int l);
    return i & (((1 << s) - 1) << (l - 1 - s));
  endfunction

  function automatic int m_bitrev(input int x, input int l);
    int y = 0;
    for (int b = 0; b < l; b++) y = (y << 1) | ((x >> b) & 1);
    return y;
  endfunction

  task automatic test_n3();
    int pat_lv[9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    int pat_ad[9] = '{0, 4, 2, 6, 1, 1, 5, 3, 7};
    int ta[12]    = '{0, 2, 4, 6,  0, 4, 1, 5,  0, 1, 2, 3};
    int tb[12]    = '{1, 3, 5, 7,  2, 6, 3, 7,  4, 5, 6, 7};
    int tt[12]    = '{0, 0, 0, 0,  0, 0, 2, 2,  0, 1, 2, 3};
    @(negedge clk);
    start3 = 1'b1;
    #1;
    check_eq("n3 idle busy", busy3, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      lv3    = pat_lv[k][0];
      #1;
      check_eq($sformatf("n3 ld_we k%0d", k), ldwe3, pat_lv[k]);
      check_eq($sformatf("n3 ld_adr k%0d", k), lda3, pat_ad[k]);
      check_eq($sformatf("n3 sel_load k%0d", k), sel3, 1);
      check_eq($sformatf("n3 wr_en in load k%0d", k), wen3, 0);
    end
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = s * 4 + i;
        @(negedge clk);
        lv3 = 1'b0;
        #1;
        check_eq($sformatf("n3 rd_a s%0d i%0d", s, i), rda3, ta[idx]);
        check_eq($sformatf("n3 rd_b s%0d i%0d", s, i), rdb3, tb[idx]);
        check_eq($sformatf("n3 tw s%0d i%0d", s, i), tw3, tt[idx]);
        check_eq($sformatf("n3 rd_bank s%0d i%0d", s, i), bank3, s % 2);
        check_eq($sformatf("n3 wr_en s%0d i%0d", s, i), wen3, (i != 0) ? 1 : 0);
        check_eq($sformatf("n3 sel_load s%0d i%0d", s, i), sel3, 0);
        if (i != 0) begin
          check_eq($sformatf("n3 wr_a s%0d i%0d", s, i), wra3, ta[idx-1]);
          check_eq($sformatf("n3 wr_b s%0d i%0d", s, i), wrb3, tb[idx-1]);
        end
      end
      @(negedge clk);
      #1;
      check_eq($sformatf("n3 drain wr_en s%0d", s), wen3, 1);
      check_eq($sformatf("n3 drain wr_a s%0d", s), wra3, ta[s*4+3]);
      check_eq($sformatf("n3 drain wr_b s%0d", s), wrb3, tb[s*4+3]);
      check_eq($sformatf("n3 drain no read s%0d", s), rda3, 0);
      check_eq($sformatf("n3 drain done s%0d", s), done3, 0);
    end
    @(negedge clk);
    #1;
    check_eq("n3 done pulse", done3, 1);
    check_eq("n3 result_bank", rbank3, 1);
    check_eq("n3 done wr_en", wen3, 0);
    @(negedge clk);
    #1;
    check_eq("n3 done cleared", done3, 0);
    check_eq("n3 idle again", busy3, 0);
  endtask

  task automatic run_frame5(input bit disturb, input int abort_at, input string nm);
    int  pa = 0;
    int  pb = 0;
    int  pw = 0;
    bit  seen = 1'b0;
    int  scale_cnt = 0;
    int  scale_bad = 0;
    @(negedge clk);
    start5 = 1'b1;
    lv5    = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      start5 = 1'b0;
      lv5    = 1'b1;
      #1;
      check_eq($sformatf("%s ld_adr k%0d", nm, k), lda5, m_bitrev(k, 5));
      check_eq($sformatf("%s ld_we k%0d", nm, k), ldwe5, 1);
      check_eq($sformatf("%s load wr_en k%0d", nm, k), wen5, 0);
    end
    for (int c = 0; c < 200 && !seen; c++) begin
      int st, pos, ea, eb, et, comp;
      @(negedge clk);
      lv5    = disturb;
      start5 = disturb && (c == 3);
      #1;
      st   = c / 17;
      pos  = c % 17;
      comp = ((c < 85) && (pos < 16)) ? 1 : 0;
      ea   = comp ? m_rotl(2 * pos, st, 5) : 0;
      eb   = comp ? m_rotl(2 * pos + 1, st, 5) : 0;
      et   = comp ? m_tw(pos, st, 5) : 0;
      check_eq($sformatf("%s rd_a c%0d", nm, c), rda5, ea);
      check_eq($sformatf("%s rd_b c%0d", nm, c), rdb5, eb);
      check_eq($sformatf("%s tw c%0d", nm, c), tw5, et);
      check_eq($sformatf("%s wr_en c%0d", nm, c), wen5, pw);
      check_eq($sformatf("%s wr_a c%0d", nm, c), wra5, pa);
      check_eq($sformatf("%s wr_b c%0d", nm, c), wrb5, pb);
      check_eq($sformatf("%s done c%0d", nm, c), done5, (c == 85) ? 1 : 0);
      check_eq($sformatf("%s ld_we c%0d", nm, c), ldwe5, 0);
      if (c <= 85) check_eq($sformatf("%s busy c%0d", nm, c), busy5, 1);
      if (c < 85) check_eq($sformatf("%s rd_bank c%0d", nm, c), bank5, st % 2);
      if (c == 85) check_eq($sformatf("%s result_bank", nm), rbank5, 1);
      if (scale5 === 1'b1) scale_cnt++;
      if ((scale5 === 1'b1) && (wen5 !== 1'b1)) scale_bad++;
      pa = ea;
      pb = eb;
      pw = comp;
      if (c == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_eq($sformatf("%s reset busy", nm), busy5, 0);
        check_eq($sformatf("%s reset wr_en", nm), wen5, 0);
        check_eq($sformatf("%s reset rd_a", nm), rda5, 0);
        check_eq($sformatf("%s reset rd_bank", nm), bank5, 0);
        check_eq($sformatf("%s reset wr_a", nm), wra5, 0);
        @(negedge clk);
        reset_n = 1'b1;
        lv5     = 1'b0;
        start5  = 1'b0;
        return;
      end
      if (done5 === 1'b1) seen = 1'b1;
    end
    lv5    = 1'b0;
    start5 = 1'b0;
    check_eq($sformatf("%s done seen (86-cycle span)", nm), seen, 1);
    check_eq($sformatf("%s bfu_scale count", nm), scale_cnt, SCALE_EXP5);
    check_eq($sformatf("%s bfu_scale without wr_en", nm), scale_bad, 0);
    @(negedge clk);
    #1;
    check_eq($sformatf("%s idle after done", nm), busy5, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start3  = 1'b0;
    lv3     = 1'b0;
    start5  = 1'b1;
    lv5     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst busy", busy5, 0);
    check_eq("rst done", done5, 0);
    check_eq("rst wr_en", wen5, 0);
    check_eq("rst ld_we", ldwe5, 0);
    check_eq("rst bfu_scale", scale5, 0);
    check_eq("rst rd_bank", bank5, 0);
    check_eq("rst result_bank", rbank5, 0);
    check_eq("rst rd_a", rda5, 0);
    check_eq("rst rd_b", rdb5, 0);
    check_eq("rst tw", tw5, 0);
    check_eq("rst wr_a", wra5, 0);
    check_eq("rst ld_adr", lda5, 0);
    check_eq("rst n3 busy", busy3, 0);
    check_eq("rst n3 rd_b", rdb3, 0);
    start5  = 1'b0;
    lv5     = 1'b0;
    reset_n = 1'b1;

    test_n3();
    run_frame5(1'b1, -1, "f5_disturb");
    run_frame5(1'b0, 41, "f5_abort");
    run_frame5(1'b0, -1, "f5_clean");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
